lcd_bl_pwr_seq: RTL
===================

# lcd_bl_pwr_seq

Backlight and power-down sequencer that sits behind the GPIO splitter. It receives `lcd_led_level`, `pwr_off_req` and the DMA-enable bit, and ramps the LCD backlight smoothly between levels. It drives the backlight PWM pin and runs the orderly shutdown: stop DMA, ramp the backlight to 0, hold, then assert the power-kill output.

## Interface
Parameters:
- `PWM_DIV`, default 64: clock cycles per PWM slot; minimum 1.
- `RAMP_DIV`, default 65536: clock cycles per ±1 backlight ramp step; minimum 1.
- `OFF_HOLD_CYC`, default 1000000: cycles the backlight stays at level 0 before power kill; minimum 1.

Ports:
- `aclk` in 1: single clock.
- `areset` in 1: asynchronous, active-high reset.
- `lcd_led_level` in 5: target backlight level, 0..31; synchronous to `aclk`.
- `pwr_off_req` in 1: shutdown request, level-sensitive; synchronous to `aclk`.
- `dma_run_en` in 1: DMA FSM enable from software.
- `dma_fsm_aresetn` out 1: gated DMA FSM reset, active-low.
- `lcd_bl_pwm` out 1: backlight PWM.
- `cur_level` out 5: level currently being ramped.
- `ramp_busy` out 1: high while `cur_level` ≠ effective target.
- `pwr_kill` out 1: power-off command; sticky until `areset`.

## Operation
- **Tick generators.**
  - Slot tick: pulses one cycle every `PWM_DIV` cycles.
  - Ramp tick: pulses one cycle every `RAMP_DIV` cycles.
  - Both are free-running from reset; the first pulse is at cycle DIV−1 after reset release.
- **PWM.**
  - The slot counter advances on each slot tick through 0..30, then wraps to 0. One PWM period is 31 slots.
  - `duty_q` is loaded from `cur_level` only when the slot counter wraps to 0, so there are no mid-period glitches.
  - `lcd_bl_pwm` = registered (`slot` < `duty_q`).
  - Level 0 gives constant low; level 31 gives constant high.
- **Effective target.** In RUN it is `lcd_led_level`; in every other state it is 0.
- **Ramp.** On a ramp tick, `cur_level` moves ±1 toward the effective target. If `cur_level` equals the target it holds. The target is sampled in the same cycle as the tick.
- **FSM states.**
  - **RUN.** `pwr_off_req`=1 → RAMP_DOWN.
  - **RAMP_DOWN.**
    - `pwr_off_req`=0 → RUN (abort; the ramp returns up to target).
    - Otherwise, when `cur_level`==0 → HOLD, and the hold counter loads `OFF_HOLD_CYC`−1.
  - **HOLD.**
    - `pwr_off_req`=0 → RUN (abort).
    - Otherwise the hold counter decrements every cycle; at 0 → KILL.
  - **KILL.** Terminal; only `areset` leaves it.
  - Abort takes priority over the `cur_level`==0 and hold-expiry transitions in the same cycle.
- **Registered outputs.**
  - `dma_fsm_aresetn` = `dma_run_en` & (state==RUN).
  - `pwr_kill` = 1 from entry to KILL onward.
- **Reset values.** All outputs and state are 0 (`lcd_bl_pwm`, `cur_level`, `duty_q`, `ramp_busy`, `pwr_kill`, `dma_fsm_aresetn`). Counters are 0 and the state is RUN.
- **Reset mid-operation.** Asserting `areset` in any state clears `pwr_kill` and returns to RUN with the backlight off. The backlight then ramps up from 0.

## Timing
- `pwr_off_req` sampled high at edge N:
  - State is RAMP_DOWN after N.
  - `dma_fsm_aresetn` is 0 after N+1.
- Ramp rate is 1 level per `RAMP_DIV` cycles. The worst case from 31 to 0 is 31 ramp ticks.
- `cur_level` reaches 0 at edge M:
  - HOLD is entered at M+1.
  - `pwr_kill` rises at M+1+`OFF_HOLD_CYC`.
- A level change reaches the PWM output at the next period start plus 1 cycle of registration.
- `ramp_busy` is registered and updated every cycle. It reflects the comparison one cycle earlier.

## Structure
- Package `lcd_bl_pkg`:
  - State enum: RUN, RAMP_DOWN, HOLD, KILL.
  - `LEVEL_W`=5.
  - `PWM_SLOTS`=31.
- Sub-module `tick_div` (parameter DIV; ports `aclk`, `areset`, `tick`), instantiated twice: once for the slot tick, once for the ramp tick.
- The top level holds the FSM, ramp, PWM compare and hold counter.

## Test plan
Bench parameters: `PWM_DIV`=2, `RAMP_DIV`=4, `OFF_HOLD_CYC`=10.
- Reset, `lcd_led_level`=5 → `cur_level` reaches 5 after 5 ramp ticks (cycle ~20). Then `lcd_bl_pwm` is high 10 of every 62 cycles, and `ramp_busy` falls.
- Level 31 → `lcd_bl_pwm` constant high; level 0 → constant low, across the full period after ramp completion.
- At level 3, set `dma_run_en`=1 then pulse `pwr_off_req`=1 (held) → `dma_fsm_aresetn` drops within 2 cycles. Level reaches 0 after 3 ramp ticks, and `pwr_kill` rises exactly 11 cycles after `cur_level`==0.
- `pwr_off_req` dropped during HOLD (hold counter at 4) → state RUN, `pwr_kill` stays 0, `dma_fsm_aresetn` returns to 1, and `cur_level` re-ramps to `lcd_led_level`.
- In KILL, toggle `pwr_off_req` and `lcd_led_level` → `pwr_kill` stays 1 and `cur_level` stays 0. Assert `areset` → all outputs 0 asynchronously.
- Change `lcd_led_level` 10→2 in mid-PWM-period → `duty_q` changes only at a slot wrap, with no short or extra pulse within the period.

Source files
------------

// File: rtl/lcd_bl_pkg.sv
// Shared types and constants for the LCD backlight / power-down sequencer.
package lcd_bl_pkg;

  localparam int unsigned LEVEL_W   = 5;
  localparam int unsigned PWM_SLOTS = 31;

  typedef enum logic [1:0] {
    StRun,
    StRampDown,
    StHold,
    StKill
  } state_e;

endpackage

// File: rtl/lcd_bl_pwr_seq_tick_div.sv
// Free-running divider: one-cycle tick every DIV cycles, first tick at cycle DIV-1.
module tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic aclk,
  input  logic areset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_bl_pwr_seq.sv
// Backlight ramp + PWM and the orderly shutdown sequencer (DMA stop, ramp to 0, hold, kill).
module lcd_bl_pwr_seq
  import lcd_bl_pkg::*;
#(
  parameter int unsigned PWM_DIV      = 64,
  parameter int unsigned RAMP_DIV     = 65536,
  parameter int unsigned OFF_HOLD_CYC = 1000000
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [LEVEL_W-1:0] lcd_led_level,
  input  logic               pwr_off_req,
  input  logic               dma_run_en,
  output logic               dma_fsm_aresetn,
  output logic               lcd_bl_pwm,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               ramp_busy,
  output logic               pwr_kill
);

  localparam int unsigned HW = (OFF_HOLD_CYC > 1) ? $clog2(OFF_HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(OFF_HOLD_CYC - 1);
  localparam logic [LEVEL_W-1:0] SLOT_LAST = LEVEL_W'(PWM_SLOTS - 1);

  logic slot_tick, ramp_tick, slot_wrap;
  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [LEVEL_W-1:0] cur_q, cur_d, slot_q, slot_d, duty_q, duty_d, target;
  logic pwm_q, busy_q, kill_q, dma_q;

  tick_div #(.DIV(PWM_DIV)) u_slot_div (
    .aclk   (aclk),
    .areset (areset),
    .tick   (slot_tick)
  );

  tick_div #(.DIV(RAMP_DIV)) u_ramp_div (
    .aclk   (aclk),
    .areset (areset),
    .tick   (ramp_tick)
  );

  // Aborts (pwr_off_req low) win over the zero-level and hold-expiry transitions.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StRun: begin
        if (pwr_off_req) state_d = StRampDown;
      end
      StRampDown: begin
        if (!pwr_off_req) begin
          state_d = StRun;
        end else if (cur_q == '0) begin
          state_d = StHold;
          hold_d  = HOLD_INIT;
        end
      end
      StHold: begin
        if (!pwr_off_req) begin
          state_d = StRun;
        end else if (hold_q == '0) begin
          state_d = StKill;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      StKill: begin
        state_d = StKill;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    target = (state_q == StRun) ? lcd_led_level : '0;
    cur_d  = cur_q;
    if (ramp_tick) begin
      if (cur_q < target) begin
        cur_d = cur_q + 1'b1;
      end else if (cur_q > target) begin
        cur_d = cur_q - 1'b1;
      end
    end
  end

  // Duty is only reloaded at the period boundary so a level change never cuts a pulse short.
  always_comb begin
    slot_wrap = slot_tick && (slot_q == SLOT_LAST);
    slot_d    = slot_q;
    duty_d    = duty_q;
    if (slot_tick) slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    if (slot_wrap) duty_d = cur_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StRun;
      hold_q  <= '0;
      cur_q   <= '0;
      slot_q  <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
      kill_q  <= 1'b0;
      dma_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cur_q   <= cur_d;
      slot_q  <= slot_d;
      duty_q  <= duty_d;
      pwm_q   <= (slot_q < duty_q);
      busy_q  <= (cur_q != target);
      kill_q  <= kill_q | (state_d == StKill);
      dma_q   <= dma_run_en & (state_q == StRun);
    end
  end

  assign dma_fsm_aresetn = dma_q;
  assign lcd_bl_pwm      = pwm_q;
  assign cur_level       = cur_q;
  assign ramp_busy       = busy_q;
  assign pwr_kill        = kill_q;

endmodule
